dog_ram1_arb: RTL
=================

# dog_ram1_arb

Arbiter for the single RAM1 port in the DoG pipeline. RAM1 is read by the address generator and written back by the result writer. This block serialises both streams onto one RAM port. Writes are posted into a small buffer so reads keep streaming, and read-after-write hazards, write starvation and end-of-frame flush are handled here. It sits between the read/write address stages and the RAM1 macro.

## Interface
Parameters:
- WBUF_DEPTH, 4, write-post buffer entries (power of two, ≥2)
- MAX_WAIT, 8, maximum cycles a buffered write may be bypassed by reads

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_valid_in  in  1  read request
- rd_addr_in  in  16  read address
- rd_ready_out  out  1  read request accepted this cycle when high with rd_valid_in
- wr_valid_in  in  1  write request
- wr_addr_in  in  16  write address
- wr_data_in  in  8  write data
- wr_ready_out  out  1  write accepted this cycle when high with wr_valid_in
- flush_in  in  1  level; drain buffer at priority
- flush_done_out  out  1  flush complete
- wbuf_level_out  out  $clog2(WBUF_DEPTH+1)  buffered write count
- ram_en_o  out  1  RAM port enable (registered)
- ram_we_o  out  1  RAM write enable (registered)
- ram_addr_o  out  16  RAM address (registered)
- ram_wdata_o  out  8  RAM write data (registered)
- ram_rdata_i  in  8  RAM read data, valid one cycle after a read enable
- rd_data_valid_out  out  1  read data valid
- rd_data_out  out  8  read data (= ram_rdata_i)

## Operation
- At most one RAM op per cycle. Grant is decided combinationally in cycle N and registered onto the ram_* outputs in N+1.
- Write force condition: buffer non-empty AND (flush_in OR buffer full OR starve_cnt==MAX_WAIT OR hazard).
- hazard: rd_valid_in and rd_addr_in equals the address of any valid buffered entry.
- Grant priority: write force → WRITE grant, rd_ready_out=0. Otherwise rd_valid_in → READ grant, rd_ready_out=1. Otherwise buffer non-empty → WRITE grant. Otherwise idle, ram_en_o=0.
- WRITE grant pops the oldest entry; FIFO order is always preserved.
- wr_ready_out = level < WBUF_DEPTH, evaluated before that cycle's pop. A full buffer does not accept a write even when it pops in the same cycle. There is no bypass: an accepted write reaches the RAM no earlier than 2 cycles after acceptance.
- starve_cnt counts cycles in which the buffer is non-empty and no WRITE is granted. It clears on a WRITE grant or when the buffer is empty, and saturates at MAX_WAIT.
- flush_done_out is registered. It is high in every cycle after one in which flush_in=1 and level==0, and low otherwise. Writes are still accepted during a flush.
- Reset mid-operation discards all buffered writes and any in-flight read. rd_data_valid_out does not assert for a read issued before reset.

## Timing
- Reset values: ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, rd_data_valid_out=0, flush_done_out=0, level=0, starve_cnt=0.
- Read latency: request accepted in N → ram_en_o=1, ram_we_o=0 in N+1 → rd_data_valid_out=1 in N+2.
- Back-to-back reads achieve 1 per cycle when no write is forced.
- Simultaneous push and pop: level is unchanged.
- rd_ready_out and wr_ready_out are combinational. The requester must hold its request stable until accepted.

## Structure
- Shared package dog_pkg: DOG_ADDR_W=16, DOG_DATA_W=8, and a typedef for the write-buffer entry (addr, data, valid).
- Sub-module dog_wbuf: circular FIFO with pointer wrap, level counter, and a parallel address-compare output (hit) used for hazard detection.
- The top level holds the grant logic, starve counter, registered RAM outputs and read-valid pipeline.

## Test plan
- Reads only, addresses 0..15 streamed: ram_en_o asserts every cycle; rd_data_valid_out follows each request 2 cycles later; data is correct.
- 5 writes pushed while reads stream continuously, WBUF_DEPTH=4: wr_ready_out=0 on the 5th write; a forced WRITE takes the next slot; no write is lost and write order is preserved.
- Write to 0x0010 buffered, then read 0x0010: rd_ready_out=0 until the write issues; the read then returns the new data.
- One buffered write with continuous reads: a forced write occurs after exactly MAX_WAIT=8 bypassed cycles.
- flush_in=1 with 3 entries buffered and no reads: 3 consecutive WRITE ops, then flush_done_out=1 on the cycle after level reaches 0.
- rst_n dropped with 2 entries buffered and a read in flight: all outputs go to their reset values immediately; no rd_data_valid_out or write appears afterwards.

Source files
------------

// File: rtl/dog_pkg.sv
// Shared DoG pipeline types: RAM1 address/data widths and the write-post entry.
package dog_pkg;

   localparam int DOG_ADDR_W = 16;
   localparam int DOG_DATA_W = 8;

   typedef struct packed {
      logic [DOG_ADDR_W-1:0] addr;
      logic [DOG_DATA_W-1:0] data;
      logic                  valid;
   } dog_wbuf_entry_t;

endpackage

// File: rtl/dog_wbuf.sv
// Write-post FIFO for RAM1: circular buffer, level counter and a parallel
// address compare against every valid entry for read-after-write detection.
module dog_wbuf
   import dog_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [DOG_ADDR_W-1:0] i_addr,
   input  logic [DOG_DATA_W-1:0] i_data,
   input  logic                  i_pop,
   input  logic [DOG_ADDR_W-1:0] i_cmp_addr,
   output logic [DOG_ADDR_W-1:0] o_head_addr,
   output logic [DOG_DATA_W-1:0] o_head_data,
   output logic [LVL_W-1:0]      o_level,
   output logic                  o_hit
);

   dog_wbuf_entry_t  r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_hit;

   // Entry storage and wrap-around pointers; pop clears the valid bit so the
   // compare only ever sees live entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_pop) begin
            r_mem[r_rd_ptr].valid <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + 1'b1;
         end
         if (i_push) begin
            r_mem[r_wr_ptr] <= '{addr: i_addr, data: i_data, valid: 1'b1};
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
      end
   end

   // Occupancy count; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Hazard compare of the requested read address against all valid entries.
   always_comb begin
      w_hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_mem[i].valid && (r_mem[i].addr == i_cmp_addr)) begin
            w_hit = 1'b1;
         end
      end
   end

   assign o_hit       = w_hit;
   assign o_level     = r_level;
   assign o_head_addr = r_mem[r_rd_ptr].addr;
   assign o_head_data = r_mem[r_rd_ptr].data;

endmodule

// File: rtl/dog_ram1_arb.sv
// RAM1 port arbiter: serialises address-generator reads and posted result
// writes onto one registered RAM port, with hazard, starvation and flush control.
module dog_ram1_arb
   import dog_pkg::*;
#(
   parameter int WBUF_DEPTH = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rd_valid_in,
   input  logic [DOG_ADDR_W-1:0]              rd_addr_in,
   output logic                               rd_ready_out,
   input  logic                               wr_valid_in,
   input  logic [DOG_ADDR_W-1:0]              wr_addr_in,
   input  logic [DOG_DATA_W-1:0]              wr_data_in,
   output logic                               wr_ready_out,
   input  logic                               flush_in,
   output logic                               flush_done_out,
   output logic [$clog2(WBUF_DEPTH+1)-1:0]    wbuf_level_out,
   output logic                               ram_en_o,
   output logic                               ram_we_o,
   output logic [DOG_ADDR_W-1:0]              ram_addr_o,
   output logic [DOG_DATA_W-1:0]              ram_wdata_o,
   input  logic [DOG_DATA_W-1:0]              ram_rdata_i,
   output logic                               rd_data_valid_out,
   output logic [DOG_DATA_W-1:0]              rd_data_out
);

   localparam int LVL_W = $clog2(WBUF_DEPTH + 1);
   localparam int STV_W = $clog2(MAX_WAIT + 1);
   localparam logic [LVL_W-1:0] DEPTH_L    = LVL_W'(WBUF_DEPTH);
   localparam logic [STV_W-1:0] MAX_WAIT_L = STV_W'(MAX_WAIT);

   logic [LVL_W-1:0]      w_level;
   logic                  w_hit;
   logic [DOG_ADDR_W-1:0] w_head_addr;
   logic [DOG_DATA_W-1:0] w_head_data;
   logic                  w_nonempty;
   logic                  w_force;
   logic                  w_grant_wr;
   logic                  w_grant_rd;
   logic                  w_push;

   logic [STV_W-1:0]      r_starve;
   logic                  r_ram_en;
   logic                  r_ram_we;
   logic [DOG_ADDR_W-1:0] r_ram_addr;
   logic [DOG_DATA_W-1:0] r_ram_wdata;
   logic                  r_rd_vld;
   logic                  r_flush_done;

   dog_wbuf #(
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_addr      (wr_addr_in),
      .i_data      (wr_data_in),
      .i_pop       (w_grant_wr),
      .i_cmp_addr  (rd_addr_in),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_level     (w_level),
      .o_hit       (w_hit)
   );

   // Grant decision: forced write, else read, else opportunistic write.
   // Acceptance uses the pre-pop level, so a full buffer never takes a write.
   always_comb begin
      w_nonempty = (w_level != '0);
      w_force    = w_nonempty && (flush_in || (w_level == DEPTH_L) ||
                                  (r_starve == MAX_WAIT_L) || (rd_valid_in && w_hit));
      w_grant_wr = w_force || (!rd_valid_in && w_nonempty);
      w_grant_rd = !w_force && rd_valid_in;
      w_push     = wr_valid_in && (w_level < DEPTH_L);
   end

   // Starvation counter: cycles a buffered write has been passed over by reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (!w_nonempty || w_grant_wr) begin
         r_starve <= '0;
      end else if (r_starve != MAX_WAIT_L) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   // Registered RAM port; address/data hold their last value when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else begin
         r_ram_en <= w_grant_wr || w_grant_rd;
         r_ram_we <= w_grant_wr;
         if (w_grant_wr) begin
            r_ram_addr  <= w_head_addr;
            r_ram_wdata <= w_head_data;
         end else if (w_grant_rd) begin
            r_ram_addr  <= rd_addr_in;
         end
      end
   end

   // Read-valid pipeline and flush completion flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld     <= 1'b0;
         r_flush_done <= 1'b0;
      end else begin
         r_rd_vld     <= r_ram_en && !r_ram_we;
         r_flush_done <= flush_in && !w_nonempty;
      end
   end

   assign rd_ready_out      = w_grant_rd;
   assign wr_ready_out      = (w_level < DEPTH_L);
   assign wbuf_level_out    = w_level;
   assign flush_done_out    = r_flush_done;
   assign ram_en_o          = r_ram_en;
   assign ram_we_o          = r_ram_we;
   assign ram_addr_o        = r_ram_addr;
   assign ram_wdata_o       = r_ram_wdata;
   assign rd_data_valid_out = r_rd_vld;
   assign rd_data_out       = ram_rdata_i;

endmodule
